logic_slice_sequencer: RTL and testbench
========================================

// Module: logic_slice_sequencer
// PURPOSE
//  Multi-cycle bitwise logic unit: streams two 32-bit operands through ONE shared
//  4-bit logic slice, lowest nibble first, 8 cycles per operation.
//  Area-reduced alternative to the fully parallel 32-bit logic blocks.
//  Owns the start/busy/done handshake with the ALU/control path and sequences the slice.
// PARAMETERS
//  DATA_W   32  operand/result width; must be a multiple of SLICE_W
//  SLICE_W  4   width of the shared logic slice
//  NSLICE   DATA_W/SLICE_W (derived localparam, 8); passes per operation
// PORTS
//  clk     in   1       single clock, rising edge
//  rst     in   1       synchronous, active-high reset
//  start   in   1       request; sampled only in IDLE or DONE
//  op      in   2       00 AND, 01 OR, 10 XOR, 11 NOR; latched with start
//  a       in   DATA_W  operand A; latched with start
//  b       in   DATA_W  operand B; latched with start
//  busy    out  1       high in RUN
//  done    out  1       one-cycle pulse; result valid
//  result  out  DATA_W  assembled result; holds until next accepted start
//  zero    out  1       result==0, valid with done (LOGIC_ZERO_FLAG_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, busy=0, done=0, result=0, zero=0. Reset mid-RUN
//   aborts the op; no done pulse; partial result discarded (result=0).
//  FSM: IDLE -start-> RUN; RUN -(idx==NSLICE-1)-> DONE; DONE -start-> RUN,
//   else -> IDLE. Registered outputs; busy=(state==RUN), done=(state==DONE).
//  Accept: edge E0 with start=1 in IDLE/DONE latches a,b,op, clears result, idx=0.
//  Run: edges E1..E8 compute slice idx and write result[idx*SLICE_W +: SLICE_W];
//   idx increments, with no wrap beyond NSLICE-1. E8 enters DONE; done high E8..E9.
//  Latency: start sampled at E0 -> done visible the cycle after E8 (9 cycles total).
//   Back-to-back: start during the DONE cycle -> RUN next edge, with no idle gap.
//  start while RUN: ignored; latched operands unchanged; no queueing.
//  Input changes after E0 have no effect; only latched copies feed the slice.
//  Result nibbles not yet processed read 0 while busy. The result is
//   architecturally valid only when done=1 or afterwards.
//  Pure bitwise ops: no carry between slices; op decode is identical for all slices.
// CONFIGURATION
//  LOGIC_ZERO_FLAG_EN defined: a zero flag is accumulated per slice (OR of slice
//   outputs). zero is registered, set with done, held with result, cleared on accept.
//  Not defined: zero port tied 0; no accumulator logic.
// STRUCTURE
//  Shared package/include: opcode constants (LOP_AND/OR/XOR/NOR), FSM state
//   encodings (ST_IDLE/ST_RUN/ST_DONE), and SLICE_W default.
//  One sub-module: logic4bit. A combinational SLICE_W-bit slice (a, b, op -> y),
//   instantiated once. It is reusable by the parallel logic units.
//  Top: FSM, idx counter, operand/op registers, result write-enable by idx.
// TESTING
//  AND a=FFFF0000 b=0F0F0F0F start 1 cycle -> busy 8 cycles, done pulse, result=0F0F0000
//  NOR a=0 b=0 -> result=FFFFFFFF; XOR a=b=A5A5A5A5 -> result=0, zero=1 (macro on)
//  start pulsed at RUN cycle 3 with new a/b -> ignored; original result, single done
//  start held high across DONE -> second op starts with no IDLE cycle; two done pulses 9 cycles apart
//  rst asserted at RUN idx=5 -> next cycle busy=0, done=0, result=0; no done pulse follows
//  change a,b,op every cycle during RUN -> result matches operands latched at E0

Source files
------------

// File: rtl/logic_slice_sequencer_pkg.sv
// Shared definitions for the slice-serial logic unit: opcodes, FSM states, slice width.
package logic_slice_sequencer_pkg;

  localparam int SLICE_W_DEF = 4;

  localparam logic [1:0] LOP_AND = 2'b00;
  localparam logic [1:0] LOP_OR  = 2'b01;
  localparam logic [1:0] LOP_XOR = 2'b10;
  localparam logic [1:0] LOP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice_sequencer_logic4bit.sv
// Combinational W-bit bitwise logic slice; shared with the parallel logic units.
module logic4bit
  import logic_slice_sequencer_pkg::*;
#(
  parameter int W = SLICE_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      LOP_AND: y = a & b;
      LOP_OR:  y = a | b;
      LOP_XOR: y = a ^ b;
      LOP_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_slice_sequencer.sv
// Streams two DATA_W operands through one shared logic slice, lowest slice first.
// Optional zero flag is built when LOGIC_ZERO_FLAG_EN is defined.
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_RUN  | one slice computed per cycle, idx 0..NSLICE-1
// ST_DONE | done pulse, result valid; start here chains the next op
module logic_slice_sequencer
  import logic_slice_sequencer_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]        op_q, op_d;
  logic [SLICE_W-1:0] a_sl, b_sl, y_sl;
  logic              accept;
  int unsigned       base;

  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign base   = 32'(idx_q) * 32'(SLICE_W);
  assign a_sl   = a_q[base +: SLICE_W];
  assign b_sl   = b_q[base +: SLICE_W];

  logic4bit #(.W(SLICE_W)) u_slice (
    .a  (a_sl),
    .b  (b_sl),
    .op (op_q),
    .y  (y_sl)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    if (accept) begin
      state_d  = ST_RUN;
      idx_d    = '0;
      a_d      = a;
      b_d      = b;
      op_d     = op;
      result_d = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          result_d[base +: SLICE_W] = y_sl;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= LOP_AND;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

`ifdef LOGIC_ZERO_FLAG_EN
  // acc_q ORs every slice output seen so far; zero resolves on the last slice.
  logic acc_q, acc_d, zero_q, zero_d;

  always_comb begin
    acc_d  = acc_q;
    zero_d = zero_q;
    if (accept) begin
      acc_d  = 1'b0;
      zero_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      acc_d = acc_q | (|y_sl);
      if (idx_q == IDX_LAST) zero_d = ~(acc_q | (|y_sl));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_logic_slice_sequencer.sv
// Scoreboard bench for logic_slice_sequencer; expected zero follows LOGIC_ZERO_FLAG_EN.
module tb_logic_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero;
  logic [31:0] result;

  logic_slice_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          e0;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic exp_zero(input logic [31:0] r);
`ifdef LOGIC_ZERO_FLAG_EN
    return (r == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check32("result", result, e.res);
          check32("zero", {31'b0, zero}, {31'b0, e.z});
          // done is seen after the 8th edge following the accept edge
          check32("latency", 32'(cyc - e.e0), 32'd8);
          check32("busy_cycles", 32'(busy_cnt), 32'd8);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] res, output int e0);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk);
    #1 e0 = cyc;
    e.res = res; e.z = exp_zero(res); e.e0 = e0;
    exp_q.push_back(e);
  endtask

  task automatic run_simple(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] res);
    int e0;
    issue(o, av, bv, res, e0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int e0, e0b, dc_before;

    repeat (3) @(negedge clk);
    check32("reset_busy", {31'b0, busy}, 32'd0);
    check32("reset_done", {31'b0, done}, 32'd0);
    check32("reset_result", result, 32'h0);
    check32("reset_zero", {31'b0, zero}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_simple(2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000);
    run_simple(2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF);

    // OR with a start pulse in RUN cycle 3 that must be ignored
    issue(2'b01, 32'h12345678, 32'h80000001, 32'h92345679, e0);
    @(negedge clk);
    start = 1'b0;
    check32("accept_clears_result", result, 32'h0);
    check32("busy_after_accept", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check32("partial_nibble0", result, 32'h00000009);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    run_simple(2'b10, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000);

    // XOR with inputs scrambled every cycle of RUN
    issue(2'b10, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hD1A2B1E0, e0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 2'(i);
    end
    repeat (4) @(negedge clk);

    // start held across DONE: OR then AND, no idle gap
    issue(2'b01, 32'h0000FFFF, 32'hFF000000, 32'hFF00FFFF, e0);
    @(negedge clk);
    op = 2'b00; a = 32'hFFFFFFFF; b = 32'h12345678;
    begin
      exp_t e;
      e.res = 32'h12345678; e.z = exp_zero(32'h12345678); e.e0 = e0 + 9;
      exp_q.push_back(e);
    end
    dc_before = done_cyc.size();
    // hold start through the DONE cycle (accept edge E9)
    repeat (8) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    if (done_cyc.size() >= dc_before + 2) begin
      check32("b2b_gap", 32'(done_cyc[dc_before + 1] - done_cyc[dc_before]), 32'd9);
    end else begin
      checks++;
      failures++;
      $display("FAIL b2b_done_count actual=%0d required=2", done_cyc.size() - dc_before);
    end

    // reset while idx=5 aborts the op
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check32("abort_busy", {31'b0, busy}, 32'd0);
    check32("abort_done", {31'b0, done}, 32'd0);
    check32("abort_result", result, 32'h0);
    rst = 1'b0;
    e0b = done_cnt;
    repeat (12) @(negedge clk);
    check32("abort_no_done", 32'(done_cnt - e0b), 32'd0);

    check32("pending_expectations", 32'(exp_q.size()), 32'd0);
    check32("total_done_pulses", 32'(done_cnt), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
